// File: rtl/s641_state_scan_ctrl_if.sv
// Bus between the s641 state/scan wrapper and the logic that drives it.
// Signal suffixes are taken from the wrapper's point of view.
interface s641_state_scan_ctrl_if #(
    parameter int NBITS = 19,
    parameter int PO_W  = 24,
    parameter int CNT_W = 16
);
    logic [NBITS-1:0] ns_i;
    logic [NBITS-1:0] ps_o;
    logic [PO_W-1:0]  po_i;
    logic             scan_en_i;
    logic             scan_in_i;
    logic             scan_out_o;
    logic             run_start_i;
    logic [CNT_W-1:0] run_len_i;
    logic             misr_en_i;
    logic             misr_clr_i;
    logic             busy_o;
    logic             done_o;
    logic [PO_W-1:0]  signature_o;

    modport master (
        output ns_i, po_i, scan_en_i, scan_in_i, run_start_i, run_len_i,
               misr_en_i, misr_clr_i,
        input  ps_o, scan_out_o, busy_o, done_o, signature_o
    );

    modport slave (
        input  ns_i, po_i, scan_en_i, scan_in_i, run_start_i, run_len_i,
               misr_en_i, misr_clr_i,
        output ps_o, scan_out_o, busy_o, done_o, signature_o
    );
endinterface

// File: rtl/s641_state_scan_ctrl.sv
// Sequential wrapper for the combinational s641 core: state register with full scan,
// counted functional bursts and a MISR over the core's primary outputs.
module s641_state_scan_ctrl #(
    parameter int               NBITS       = 19,
    parameter int               PO_W        = 24,
    parameter int               CNT_W       = 16,
    parameter logic [NBITS-1:0] RESET_STATE = 19'h00000,
    parameter logic [PO_W-1:0]  MISR_SEED   = 24'h000000,
    parameter logic [PO_W-1:0]  MISR_POLY   = 24'hE10000
) (
    input  logic                  clk,
    input  logic                  rst,
    s641_state_scan_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [NBITS-1:0] ps_q, ps_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PO_W-1:0]  sig_q, sig_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             misr_upd_s;

    // Shift left with the tap parity feeding bit 0, then fold in the core outputs.
    function automatic logic [PO_W-1:0] misr_next(input logic [PO_W-1:0] sig,
                                                  input logic [PO_W-1:0] po);
        logic [PO_W-1:0] nxt;
        nxt = {sig[PO_W-2:0], ^(sig & MISR_POLY)} ^ po;
        return nxt;
    endfunction

    // Next-state, counter, state-register and signature computation.
    always_comb begin
        state_d    = state_q;
        ps_d       = ps_q;
        cnt_d      = cnt_q;
        misr_upd_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.scan_en_i) begin
                    ps_d = {ps_q[NBITS-2:0], bus.scan_in_i};
                end else if (bus.run_start_i) begin
                    if (bus.run_len_i == {CNT_W{1'b0}}) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = bus.run_len_i;
                        state_d = ST_RUN;
                    end
                end else begin
                    ps_d = ps_q;
                end
            end
            ST_RUN: begin
                ps_d       = bus.ns_i;
                cnt_d      = cnt_q - CNT_W'(1'b1);
                misr_upd_s = bus.misr_en_i;
                if (cnt_q == CNT_W'(1'b1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A clear wins over a same-cycle compaction.
        if (bus.misr_clr_i) begin
            sig_d = MISR_SEED;
        end else if (misr_upd_s) begin
            sig_d = misr_next(sig_q, bus.po_i);
        end else begin
            sig_d = sig_q;
        end

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State, counter, signature and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ps_q    <= RESET_STATE;
            cnt_q   <= {CNT_W{1'b0}};
            sig_q   <= MISR_SEED;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ps_q    <= ps_d;
            cnt_q   <= cnt_d;
            sig_q   <= sig_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.ps_o        = ps_q;
    assign bus.scan_out_o  = ps_q[NBITS-1];
    assign bus.signature_o = sig_q;
    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;

endmodule

// File: tb/tb_s641_state_scan_ctrl.sv
// Self-checking bench for s641_state_scan_ctrl: directed scenarios plus randomized bursts
// against a behavioural model, and a closed loop with a stand-in next-state core.
module tb_s641_state_scan_ctrl;
    localparam int NB = 19;
    localparam int PW = 24;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          loop_mode = 1'b0;
    logic [NB-1:0] ns_drv = '0;
    logic [PW-1:0] po_drv = '0;
    logic [NB-1:0] exp_ps = '0;
    logic [PW-1:0] exp_sig = '0;
    int            total = 0;
    int            bad = 0;

    s641_state_scan_ctrl_if #(.NBITS(NB), .PO_W(PW), .CNT_W(CW)) bus ();

    s641_state_scan_ctrl #(.NBITS(NB), .PO_W(PW), .CNT_W(CW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Stand-in core: arithmetic next state and outputs derived from present state.
    function automatic logic [NB-1:0] core_ns(input logic [NB-1:0] p);
        logic [31:0] w;
        w = {13'd0, p} * 32'd5 + 32'h0000ABCD;
        return w[NB-1:0];
    endfunction

    function automatic logic [PW-1:0] core_po(input logic [NB-1:0] p);
        logic [31:0] w;
        w = ({13'd0, p} * 32'd3) ^ ({13'd0, p} << 5);
        return w[PW-1:0];
    endfunction

    // Signature model: double the value modulo 2^24, xor the outputs and the tap parity.
    function automatic logic [PW-1:0] ref_misr(input logic [PW-1:0] s, input logic [PW-1:0] p);
        logic [31:0] w;
        int unsigned fb;
        fb = $countones(s & 24'hE10000) % 2;
        w  = {8'd0, s} * 32'd2;
        return w[PW-1:0] ^ p ^ PW'(fb);
    endfunction

    assign bus.ns_i = loop_mode ? core_ns(bus.ps_o) : ns_drv;
    assign bus.po_i = loop_mode ? core_po(bus.ps_o) : po_drv;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        total++; if (bus.ps_o !== 19'h00000) begin bad++; $display("FAIL reset_ps got=%h exp=%h", bus.ps_o, 19'h00000); end
        total++; if (bus.signature_o !== 24'h000000) begin bad++; $display("FAIL reset_sig got=%h exp=%h", bus.signature_o, 24'h000000); end
        total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
        total++; if (bus.done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done_o); end
        exp_ps  = '0;
        exp_sig = '0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_scan(input logic [NB-1:0] v);
        logic [NB-1:0] fill;
        fill = ~v;
        for (int i = NB - 1; i >= 0; i--) begin
            bus.scan_en_i = 1'b1;
            bus.scan_in_i = v[i];
            tick();
        end
        bus.scan_en_i = 1'b0;
        total++; if (bus.ps_o !== v) begin bad++; $display("FAIL scan_load got=%h exp=%h", bus.ps_o, v); end
        for (int i = NB - 1; i >= 0; i--) begin
            total++; if (bus.scan_out_o !== v[i]) begin bad++; $display("FAIL scan_out bit=%0d got=%b exp=%b", i, bus.scan_out_o, v[i]); end
            bus.scan_en_i = 1'b1;
            bus.scan_in_i = fill[i];
            tick();
        end
        bus.scan_en_i = 1'b0;
        bus.scan_in_i = 1'b0;
        total++; if (bus.ps_o !== fill) begin bad++; $display("FAIL scan_refill got=%h exp=%h", bus.ps_o, fill); end
        exp_ps = fill;
    endtask

    task automatic test_misr_arith();
        bus.misr_clr_i = 1'b1;
        tick();
        bus.misr_clr_i = 1'b0;
        total++; if (bus.signature_o !== 24'h000000) begin bad++; $display("FAIL misr_clr_idle got=%h exp=%h", bus.signature_o, 24'h000000); end
        ns_drv = exp_ps;
        bus.misr_en_i = 1'b1;
        bus.run_len_i = 16'd2;
        bus.run_start_i = 1'b1;
        tick();
        bus.run_start_i = 1'b0;
        po_drv = 24'h000001;
        tick();
        total++; if (bus.signature_o !== 24'h000001) begin bad++; $display("FAIL misr_step1 got=%h exp=%h", bus.signature_o, 24'h000001); end
        po_drv = 24'h000000;
        tick();
        total++; if (bus.signature_o !== 24'h000002) begin bad++; $display("FAIL misr_step2 got=%h exp=%h", bus.signature_o, 24'h000002); end
        tick();
        bus.misr_clr_i = 1'b1;
        tick();
        bus.misr_clr_i = 1'b0;
        bus.run_start_i = 1'b1;
        tick();
        bus.run_start_i = 1'b0;
        po_drv = 24'h800000;
        tick();
        total++; if (bus.signature_o !== 24'h800000) begin bad++; $display("FAIL misr_msb_load got=%h exp=%h", bus.signature_o, 24'h800000); end
        po_drv = 24'h000000;
        tick();
        total++; if (bus.signature_o !== 24'h000001) begin bad++; $display("FAIL misr_wrap got=%h exp=%h", bus.signature_o, 24'h000001); end
        tick();
        bus.misr_en_i = 1'b0;
        exp_sig = 24'h000001;
    endtask

    task automatic test_burst_three();
        int cyc;
        ns_drv = 19'h7FFFF;
        bus.run_len_i = 16'd3;
        bus.run_start_i = 1'b1;
        tick();
        bus.run_start_i = 1'b0;
        cyc = 0;
        while (bus.busy_o === 1'b1 && cyc < 10) begin
            cyc++;
            tick();
        end
        total++; if (cyc != 3) begin bad++; $display("FAIL burst3_busy_cycles got=%0d exp=3", cyc); end
        total++; if (bus.done_o !== 1'b1) begin bad++; $display("FAIL burst3_done got=%b exp=1", bus.done_o); end
        total++; if (bus.ps_o !== 19'h7FFFF) begin bad++; $display("FAIL burst3_ps got=%h exp=%h", bus.ps_o, 19'h7FFFF); end
        exp_ps = 19'h7FFFF;
        tick();
        total++; if (bus.done_o !== 1'b0) begin bad++; $display("FAIL burst3_done_width got=%b exp=0", bus.done_o); end
    endtask

    // Generic burst; noise toggles scan/start during RUN and DONE, which must be ignored.
    task automatic run_burst(input int n, input logic me, input int clr_at, input logic noise);
        bus.run_len_i = n[CW-1:0];
        bus.misr_en_i = me;
        bus.run_start_i = 1'b1;
        tick();
        bus.run_start_i = 1'b0;
        bus.run_len_i = 16'($urandom);
        for (int c = 0; c < n; c++) begin
            total++; if (bus.busy_o !== 1'b1 || bus.done_o !== 1'b0) begin bad++; $display("FAIL run_status cyc=%0d busy=%b done=%b exp busy=1 done=0", c, bus.busy_o, bus.done_o); end
            ns_drv = NB'($urandom);
            po_drv = PW'($urandom);
            bus.misr_clr_i = (c == clr_at);
            if (noise) begin
                bus.scan_en_i   = 1'($urandom);
                bus.scan_in_i   = 1'($urandom);
                bus.run_start_i = 1'($urandom);
            end
            exp_ps = ns_drv;
            if (c == clr_at) exp_sig = 24'h000000;
            else if (me) exp_sig = ref_misr(exp_sig, po_drv);
            tick();
        end
        bus.misr_clr_i  = 1'b0;
        bus.scan_en_i   = noise;
        bus.scan_in_i   = noise;
        bus.run_start_i = noise;
        total++; if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b1) begin bad++; $display("FAIL run_end n=%0d busy=%b done=%b exp busy=0 done=1", n, bus.busy_o, bus.done_o); end
        total++; if (bus.ps_o !== exp_ps) begin bad++; $display("FAIL run_ps n=%0d got=%h exp=%h", n, bus.ps_o, exp_ps); end
        total++; if (bus.signature_o !== exp_sig) begin bad++; $display("FAIL run_sig n=%0d got=%h exp=%h", n, bus.signature_o, exp_sig); end
        tick();
        bus.scan_en_i   = 1'b0;
        bus.scan_in_i   = 1'b0;
        bus.run_start_i = 1'b0;
        total++; if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.ps_o !== exp_ps) begin bad++; $display("FAIL after_done busy=%b done=%b ps=%h exp 0 0 %h", bus.busy_o, bus.done_o, bus.ps_o, exp_ps); end
        bus.misr_en_i = 1'b0;
    endtask

    task automatic test_random_bursts();
        for (int k = 0; k < 8; k++) begin
            int n;
            int ca;
            n  = int'($urandom_range(0, 9));
            ca = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 9)) : -1;
            run_burst(n, 1'($urandom), ca, 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        run_burst(4, 1'b1, -1, 1'b0);
        run_burst(1, 1'b1, -1, 1'b0);
        run_burst(5, 1'b1, 4, 1'b1);
    endtask

    task automatic test_closed_loop();
        logic [NB-1:0] gps;
        logic [PW-1:0] gsig;
        int cyc;
        test_scan(19'h13579);
        bus.misr_clr_i = 1'b1;
        tick();
        bus.misr_clr_i = 1'b0;
        gps  = exp_ps;
        gsig = 24'h000000;
        for (int k = 0; k < 50; k++) begin
            gsig = ref_misr(gsig, core_po(gps));
            gps  = core_ns(gps);
        end
        loop_mode = 1'b1;
        bus.misr_en_i = 1'b1;
        bus.run_len_i = 16'd50;
        bus.run_start_i = 1'b1;
        tick();
        bus.run_start_i = 1'b0;
        cyc = 0;
        while (bus.busy_o === 1'b1 && cyc < 80) begin
            cyc++;
            tick();
        end
        total++; if (cyc != 50) begin bad++; $display("FAIL loop_cycles got=%0d exp=50", cyc); end
        total++; if (bus.done_o !== 1'b1) begin bad++; $display("FAIL loop_done got=%b exp=1", bus.done_o); end
        total++; if (bus.ps_o !== gps) begin bad++; $display("FAIL loop_ps got=%h exp=%h", bus.ps_o, gps); end
        total++; if (bus.signature_o !== gsig) begin bad++; $display("FAIL loop_sig got=%h exp=%h", bus.signature_o, gsig); end
        tick();
        loop_mode = 1'b0;
        bus.misr_en_i = 1'b0;
        exp_ps  = gps;
        exp_sig = gsig;
    endtask

    task automatic test_reset_mid_run();
        int done_seen;
        bus.misr_en_i = 1'b1;
        bus.run_len_i = 16'd10;
        bus.run_start_i = 1'b1;
        tick();
        bus.run_start_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            ns_drv = NB'($urandom) | 19'h00001;
            po_drv = PW'($urandom) | 24'h000001;
            tick();
        end
        #2 rst = 1'b1;
        #1;
        total++; if (bus.ps_o !== 19'h00000) begin bad++; $display("FAIL midrst_ps got=%h exp=%h", bus.ps_o, 19'h00000); end
        total++; if (bus.signature_o !== 24'h000000) begin bad++; $display("FAIL midrst_sig got=%h exp=%h", bus.signature_o, 24'h000000); end
        total++; if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin bad++; $display("FAIL midrst_status busy=%b done=%b exp 0 0", bus.busy_o, bus.done_o); end
        tick();
        rst = 1'b0;
        bus.misr_en_i = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.done_o !== 1'b0) done_seen++;
        end
        total++; if (done_seen != 0) begin bad++; $display("FAIL midrst_no_done got=%0d pulses exp=0", done_seen); end
    endtask

    initial begin
        bus.scan_en_i   = 1'b0;
        bus.scan_in_i   = 1'b0;
        bus.run_start_i = 1'b0;
        bus.run_len_i   = 16'd0;
        bus.misr_en_i   = 1'b0;
        bus.misr_clr_i  = 1'b0;
        test_reset();
        test_scan(19'h5A5A5);
        test_misr_arith();
        test_burst_three();
        run_burst(0, 1'b1, -1, 1'b0);
        run_burst(6, 1'b1, 2, 1'b1);
        test_scan(NB'($urandom));
        test_random_bursts();
        test_back_to_back();
        test_closed_loop();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "bench timeout");
    end
endmodule
